// File: rtl/utils_top.sv
// Shared memory-interface types and helpers for the core/memory boundary.
// Also used by the memory-access stage so both sides agree on which addresses fault.
package utils_top;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_rsp_state_t;

  localparam int MEM_WORD_W = 32;

  // Misaligned word access, or any address bit set above the implemented range.
  function automatic logic main_mem_addr_bad(input logic [31:0] addr, input int byte_add_w);
    return (addr[1:0] != 2'b00) || ((addr >> byte_add_w) != 32'd0);
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// Single-port word RAM: write and read both happen on the enabled edge; rdat is the pre-write word.
// Latency: rdat valid the cycle after en; no backpressure, one access per cycle.
module main_mem_array
  import utils_top::*;
#(
  parameter int IDX_W = 6
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [MEM_WORD_W-1:0] wdat,
  output logic [MEM_WORD_W-1:0] rdat
);

  logic [MEM_WORD_W-1:0] mem_q [2**IDX_W];
  logic [MEM_WORD_W-1:0] rdat_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdat;
      end
      rdat_q <= mem_q[idx];
    end
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/main_mem_responder.sv
// Main data-memory responder: one word read/write at a time, one-cycle mem_rdy pulse with mem_err.
// Latency: writes 1 cycle, reads RD_LAT cycles; requests held by the initiator until mem_rdy (ignored while BUSY).
module main_mem_responder
  import utils_top::*;
#(
  parameter int MAIN_MEM_BYTE_ADD_W = 8,
  parameter int RD_LAT              = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_cs,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [MEM_WORD_W-1:0] mem_dat_in,
  output logic [MEM_WORD_W-1:0] mem_dat_out,
  output logic                  mem_rdy,
  output logic                  mem_err
);

  localparam int         IDX_W    = MAIN_MEM_BYTE_ADD_W - 2;
  localparam logic [3:0] CNT_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  mem_rsp_state_t        state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  is_rd_q, is_rd_d;
  logic                  bad_q, bad_d;
  logic                  err_q, err_d;
  logic [MEM_WORD_W-1:0] dout_q, dout_d;

  logic                  addr_bad;
  logic                  accept;
  logic                  rd_done;
  logic [MEM_WORD_W-1:0] arr_rdat;
  logic [MEM_WORD_W-1:0] rd_val;

  assign addr_bad = main_mem_addr_bad(mem_addr, MAIN_MEM_BYTE_ADD_W);
  assign accept   = mem_cs && (state_q != BUSY);
  assign rd_done  = (state_q == DONE) && is_rd_q;
  assign rd_val   = bad_q ? '0 : arr_rdat;

  main_mem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (accept),
    .we   (mem_wen && !addr_bad),
    .idx  (mem_addr[MAIN_MEM_BYTE_ADD_W-1:2]),
    .wdat (mem_dat_in),
    .rdat (arr_rdat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    dout_d  = rd_done ? rd_val : dout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          is_rd_d = !mem_wen;
          bad_d   = addr_bad;
          if (mem_wen || (RD_LAT == 1)) begin
            state_d = DONE;
            err_d   = addr_bad;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          err_d   = bad_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      is_rd_q <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Read data is presented straight from the array register during DONE, then held in dout_q.
  assign mem_dat_out = rd_done ? rd_val : dout_q;
  assign mem_rdy     = (state_q == DONE);
  assign mem_err     = err_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: RD_LAT=2 instance plus an RD_LAT=1 instance for streaming.
module tb_main_mem_responder;

  typedef struct {
    int unsigned cyc;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] edat;
    logic        eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_cs = 1'b0, mem_wen = 1'b0;
  logic [31:0] mem_addr = '0, mem_dat_in = '0, mem_dat_out;
  logic        mem_rdy, mem_err;
  logic        cs1 = 1'b0, wen1 = 1'b0;
  logic [31:0] addr1 = '0, din1 = '0, dat1;
  logic        rdy1, err1;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_rd = '0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  vec_t        vecs1[5];

  main_mem_responder #(.MAIN_MEM_BYTE_ADD_W(8), .RD_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_cs(mem_cs), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out), .mem_rdy(mem_rdy), .mem_err(mem_err)
  );

  main_mem_responder #(.MAIN_MEM_BYTE_ADD_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_cs(cs1), .mem_wen(wen1), .mem_addr(addr1),
    .mem_dat_in(din1), .mem_dat_out(dat1), .mem_rdy(rdy1), .mem_err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rdy) begin
      if (q0.size() == 0) begin
        chk("dut0_spurious_rdy", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_rdy_cycle", cyc, e0.cyc);
        chk("dut0_dat", mem_dat_out, e0.dat);
        chk("dut0_err", {31'd0, mem_err}, {31'd0, e0.err});
      end
    end else if (mem_err) begin
      chk("dut0_err_without_rdy", 32'd1, 32'd0);
    end
    if (rdy1) begin
      if (q1.size() == 0) begin
        chk("dut1_spurious_rdy", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_rdy_cycle", cyc, e1.cyc);
        chk("dut1_dat", dat1, e1.dat);
        chk("dut1_err", {31'd0, err1}, {31'd0, e1.err});
      end
    end else if (err1) begin
      chk("dut1_err_without_rdy", 32'd1, 32'd0);
    end
  end

  // Issue one request, hold it through the expected latency, then drop mem_cs.
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] edat, input logic eerr, input int lat);
    exp_t e;
    mem_cs     = 1'b1;
    mem_wen    = we;
    mem_addr   = addr;
    mem_dat_in = din;
    @(posedge clk);
    e.cyc = cyc + lat;
    e.dat = edat;
    e.err = eerr;
    q0.push_back(e);
    repeat (lat - 1) @(posedge clk);
    #1 mem_cs = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for 3 cycles, released asynchronously mid-cycle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'd0, mem_rdy}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_dat", mem_dat_out, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, mem_rdy}, 32'd0);
    chk("post_rst_dat", mem_dat_out, 32'd0);
    idle();

    // Write then read.
    req(1'b1, 32'h10, 32'hDEADBEEF, last_rd, 1'b0, 1);
    idle();
    last_rd = 32'hDEADBEEF;
    req(1'b0, 32'h10, 32'h0, last_rd, 1'b0, 2);
    idle();

    // Misaligned write must not disturb memory or mem_dat_out.
    req(1'b1, 32'h13, 32'h12345678, last_rd, 1'b1, 1);
    idle();
    req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    idle();

    // Out-of-bounds read returns zero data with error.
    last_rd = 32'h0;
    req(1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 2);
    idle();

    // Back-to-back: read accepted in the write's DONE cycle.
    req(1'b1, 32'h04, 32'hA5A5A5A5, last_rd, 1'b0, 1);
    last_rd = 32'hA5A5A5A5;
    req(1'b0, 32'h04, 32'h0, last_rd, 1'b0, 2);
    idle();

    // Reset during BUSY drops the read; no response expected.
    mem_cs   = 1'b1;
    mem_wen  = 1'b0;
    mem_addr = 32'h10;
    @(posedge clk);
    #1 rst_n = 1'b0;
    mem_cs = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy", {31'd0, mem_rdy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    last_rd = 32'hDEADBEEF;
    req(1'b0, 32'h10, 32'h0, last_rd, 1'b0, 2);
    idle();

    // RD_LAT=1 instance streaming with mem_cs held high: one response per cycle.
    vecs1[0] = '{1'b1, 32'h04, 32'hA5A5A5A5, 32'h0,      1'b0};
    vecs1[1] = '{1'b0, 32'h04, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs1[2] = '{1'b1, 32'h08, 32'h00001111, 32'hA5A5A5A5, 1'b0};
    vecs1[3] = '{1'b0, 32'h08, 32'h0,        32'h00001111, 1'b0};
    vecs1[4] = '{1'b0, 32'h13, 32'h0,        32'h0,      1'b1};
    for (int i = 0; i < 5; i++) begin
      cs1   = 1'b1;
      wen1  = vecs1[i].we;
      addr1 = vecs1[i].addr;
      din1  = vecs1[i].din;
      @(posedge clk);
      e1.cyc = cyc + 1;
      e1.dat = vecs1[i].edat;
      e1.err = vecs1[i].eerr;
      q1.push_back(e1);
      #1;
    end
    cs1 = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dut0_queue_drained", q0.size(), 32'd0);
    chk("dut1_queue_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
Memory-side responder for the data-memory interface driven by the memory-access stage (mem_cs / mem_wen / mem_addr / mem_dat_in / mem_dat_out). It holds the main data memory and services one word read or write at a time, with a configurable read latency. Every transaction completes with a one-cycle ready pulse and an error flag. Misaligned and out-of-bounds accesses are flagged on the memory side, matching the stage's exception checks. The block sits at the top level between the CPU core and the main-memory storage.

Parameters:
MAIN_MEM_BYTE_ADD_W, 8, byte address width of main memory [bits]; the array holds 2^(MAIN_MEM_BYTE_ADD_W-2) 32-bit words
RD_LAT, 2, read latency [cycles] from request acceptance to the read response; legal range 1..15

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active-low
mem_cs  input  1  chip-select; request valid when high
mem_wen  input  1  write enable; 1 = store, 0 = load
mem_addr  input  32  byte address
mem_dat_in  input  32  store data (memory POV)
mem_dat_out  output  32  load data (memory POV)
mem_rdy  output  1  one-cycle response pulse
mem_err  output  1  response error; qualified by mem_rdy

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: mem_dat_out=0, mem_rdy=0, mem_err=0, FSM=IDLE, latency counter=0.
- Reset does not clear array contents.
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: read latency counting.
  - DONE: response cycle; mem_rdy=1.
- Acceptance: a request is accepted on a rising edge when mem_cs=1 and FSM is IDLE or DONE.
  - DONE acceptance gives back-to-back service with no gap cycle.
  - mem_cs is ignored in BUSY. The initiator must hold the request until mem_rdy.
- Address check at acceptance:
  - bad = (addr[1:0]!=0) | (|addr[31:MAIN_MEM_BYTE_ADD_W]).
  - Word index = addr[MAIN_MEM_BYTE_ADD_W-1:2].
- Write, good address:
  - Array word is written on the acceptance edge.
  - FSM goes to DONE; mem_rdy=1, mem_err=0 in the following cycle.
  - mem_dat_out is unchanged.
- Write, bad address:
  - No array update.
  - DONE with mem_err=1.
- Read:
  - Array is read synchronously at acceptance. Captured address, data and err are held in a response register.
  - RD_LAT=1: goes directly to DONE.
  - RD_LAT>1: goes to BUSY with counter=RD_LAT-2. Counter decrements each cycle; at 0, FSM goes to DONE.
  - mem_rdy is therefore high exactly RD_LAT cycles after the acceptance edge.
  - mem_dat_out is loaded on entry to DONE: array data if good, 32'h0 with mem_err=1 if bad.
- mem_dat_out holds its last read value until the next read response. Writes never alter it.
- DONE lasts one cycle. It exits to IDLE if mem_cs=0, or accepts a new request if mem_cs=1.
- mem_err is 0 whenever mem_rdy=0.
- Read-after-write: a write accepted in cycle N is visible to a read accepted in cycle N+1 or later. The array is single-port and serialized by the FSM.
- Reset mid-operation:
  - A pending read is dropped; no mem_rdy.
  - A write already accepted has been committed.
- Arithmetic: counter width is 4 bits. No wrap occurs because the counter stops at 0.

Decomposition:
- Shared package utils_top gains:
  - typedef enum mem_rsp_state_t {IDLE, BUSY, DONE}
  - constant MEM_WORD_W = 32
  - function main_mem_addr_bad(addr, MAIN_MEM_BYTE_ADD_W), shared with the exception logic in the memory-access stage
- One sub-module: main_mem_array, a single-port word RAM with synchronous write and synchronous read.
  - Ports: clk, en, we, idx, wdat, rdat.
  - The FSM, counter, error logic and response register live in main_mem_responder.

Test Plan:
1. Reset: rst_n low for 3 cycles -> mem_rdy=0, mem_err=0, mem_dat_out=0; rst_n deasserted asynchronously mid-cycle -> outputs remain 0.
2. Write then read (RD_LAT=2): write 0xDEADBEEF @0x10 -> mem_rdy pulse 1 cycle later, err=0; read @0x10 -> mem_rdy exactly 2 cycles after acceptance, mem_dat_out=0xDEADBEEF, err=0.
3. Misaligned write: 0x12345678 @0x13 -> mem_rdy with mem_err=1; subsequent read @0x10 still returns 0xDEADBEEF.
4. Out-of-bounds read: @0x100 with MAIN_MEM_BYTE_ADD_W=8 -> mem_rdy after 2 cycles, mem_err=1, mem_dat_out=0.
5. Back-to-back: mem_cs held high for write 0xA5A5A5A5 @0x04 then read @0x04 -> read accepted in the DONE cycle; rdy pulses at t+1 and t+3, data=0xA5A5A5A5; also run with RD_LAT=1 -> rdy every cycle.
6. Reset mid-read: read @0x10 accepted, rst_n low during BUSY -> no mem_rdy; after release FSM is IDLE and a new read @0x10 returns 0xDEADBEEF.
